// File: rtl/mult_rr_scheduler_if.sv
// Operand, multiplier and result signals shared by the scheduler and its environment.
// The scheduler uses the slave view; producers, consumer and the multiplier use the master view.
interface mult_rr_scheduler_if #(
    parameter int WIDTH   = 9,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       REQ_VALID;
    logic [NUM_REQ*WIDTH-1:0] REQ_A;
    logic [NUM_REQ*WIDTH-1:0] REQ_B;
    logic [NUM_REQ-1:0]       REQ_READY;
    logic [WIDTH-1:0]         MUL_A;
    logic [WIDTH-1:0]         MUL_B;
    logic [2*WIDTH-1:0]       MUL_P;
    logic                     RES_VALID;
    logic [2*WIDTH-1:0]       RES_DATA;
    logic [ID_W-1:0]          RES_ID;
    logic                     RES_READY;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, MUL_P, RES_READY,
        input  REQ_READY, MUL_A, MUL_B, RES_VALID, RES_DATA, RES_ID
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, MUL_P, RES_READY,
        output REQ_READY, MUL_A, MUL_B, RES_VALID, RES_DATA, RES_ID
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational multiplier among NUM_REQ requesters.
// One product in flight at a time: IDLE (grant) -> MUL (multiplier settles) -> HOLD (result offered).
module mult_rr_scheduler #(
    parameter int WIDTH   = 9,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic                CLK,
    input logic                RST_N,
    mult_rr_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_r;
    logic [ID_W-1:0]      ptr_r;
    logic [WIDTH-1:0]     mul_a_r;
    logic [WIDTH-1:0]     mul_b_r;
    logic [2*WIDTH-1:0]   res_data_r;
    logic [ID_W-1:0]      res_id_r;
    logic                 res_valid_r;

    logic [WIDTH-1:0]     req_a_s [NUM_REQ];
    logic [WIDTH-1:0]     req_b_s [NUM_REQ];
    logic                 win_found_s;
    logic [ID_W-1:0]      win_idx_s;
    logic [ID_W-1:0]      ptr_next_s;
    logic [NUM_REQ-1:0]   ready_s;

    // Unpack the per-requester operand slices
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a_s[i] = bus.REQ_A[i*WIDTH +: WIDTH];
            req_b_s[i] = bus.REQ_B[i*WIDTH +: WIDTH];
        end
    end

    // Rotating-priority search: first valid requester at or after ptr_r, wrapping modulo NUM_REQ
    always_comb begin
        int              pos_v;
        logic [ID_W-1:0] idx_v;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        pos_v       = 0;
        idx_v       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_v = (int'(ptr_r) + k) % NUM_REQ;
            idx_v = pos_v[ID_W-1:0];
            if (!win_found_s && bus.REQ_VALID[idx_v]) begin
                win_found_s = 1'b1;
                win_idx_s   = idx_v;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pointer advances to the requester after the winner, wrapping at NUM_REQ
    always_comb begin
        ptr_next_s = '0;
        if (win_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_idx_s + ID_W'(1);
        end
    end

    // One-hot grant, only offered in IDLE and never while reset is asserted
    always_comb begin
        ready_s = '0;
        if (RST_N && (state_r == ST_IDLE) && win_found_s) begin
            ready_s[win_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Scheduler state machine with registered multiplier operands and result
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            res_data_r  <= '0;
            res_id_r    <= '0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        mul_a_r  <= req_a_s[win_idx_s];
                        mul_b_r  <= req_b_s[win_idx_s];
                        res_id_r <= win_idx_s;
                        ptr_r    <= ptr_next_s;
                        state_r  <= ST_MUL;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    res_data_r  <= bus.MUL_P;
                    res_valid_r <= 1'b1;
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.RES_READY) begin
                        res_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_HOLD;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_READY = ready_s;
    assign bus.MUL_A     = mul_a_r;
    assign bus.MUL_B     = mul_b_r;
    assign bus.RES_VALID = res_valid_r;
    assign bus.RES_DATA  = res_data_r;
    assign bus.RES_ID    = res_id_r;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler (WIDTH=9, NUM_REQ=4) with an ideal multiplier model
// on the MUL_* ports and hand-computed expected products, grants and IDs.
module tb_mult_rr_scheduler;

    localparam int WIDTH   = 9;
    localparam int NUM_REQ = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    int n_cmp     = 0;
    int n_err     = 0;
    int n_grant   = 0;
    int n_rv_rise = 0;
    logic rv_q    = 1'b0;

    int vals [10] = '{0, 1, 2, 3, 170, 255, 256, 341, 510, 511};

    mult_rr_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    mult_rr_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    assign bus.MUL_P = 18'(bus.MUL_A) * 18'(bus.MUL_B);

    always #5 CLK = ~CLK;

    // Count accepted operand handshakes and rising edges of RES_VALID
    always @(posedge CLK) begin
        if (RST_N && ((bus.REQ_VALID & bus.REQ_READY) != 4'b0000)) n_grant <= n_grant + 1;
        if (bus.RES_VALID && !rv_q) n_rv_rise <= n_rv_rise + 1;
        rv_q <= bus.RES_VALID;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.REQ_A[i*WIDTH +: WIDTH] = a[8:0];
        bus.REQ_B[i*WIDTH +: WIDTH] = b[8:0];
    endtask

    // Starts in an IDLE cycle with inputs applied; ends in the following IDLE cycle (RES_READY=1)
    task automatic run_one(input logic [3:0] g, input int id, input int prod, input bit clr);
        chk("grant", 32'(bus.REQ_READY), 32'(g));
        tick();
        if (clr) bus.REQ_VALID = bus.REQ_VALID & ~g;
        chk("mul_res_valid", 32'(bus.RES_VALID), 32'd0);
        chk("mul_req_ready", 32'(bus.REQ_READY), 32'd0);
        tick();
        chk("res_valid", 32'(bus.RES_VALID), 32'd1);
        chk("res_data", 32'(bus.RES_DATA), 32'(prod));
        chk("res_id", 32'(bus.RES_ID), 32'(id));
        tick();
    endtask

    initial begin
        bus.REQ_VALID = 4'b1111;
        bus.REQ_A     = '0;
        bus.REQ_B     = '0;
        bus.RES_READY = 1'b0;

        // Reset state, with requests pending during reset
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
        chk("rst_res_data", 32'(bus.RES_DATA), 32'd0);
        chk("rst_res_id", 32'(bus.RES_ID), 32'd0);
        chk("rst_mul_a", 32'(bus.MUL_A), 32'd0);
        chk("rst_mul_b", 32'(bus.MUL_B), 32'd0);
        bus.REQ_VALID = 4'b0000;
        RST_N = 1'b1;
        tick();
        chk("idle_req_ready", 32'(bus.REQ_READY), 32'd0);

        // Single request from requester 1
        set_op(1, 300, 511);
        bus.REQ_VALID = 4'b0010;
        #1;
        chk("single_grant", 32'(bus.REQ_READY), 32'b0010);
        tick();
        bus.REQ_VALID = 4'b0000;
        chk("single_mul_a", 32'(bus.MUL_A), 32'd300);
        chk("single_mul_b", 32'(bus.MUL_B), 32'd511);
        chk("single_mul_rv", 32'(bus.RES_VALID), 32'd0);
        tick();
        chk("single_rv", 32'(bus.RES_VALID), 32'd1);
        chk("single_data", 32'(bus.RES_DATA), 32'd153300);
        chk("single_id", 32'(bus.RES_ID), 32'd1);
        bus.RES_READY = 1'b1;
        tick();
        chk("single_done_rv", 32'(bus.RES_VALID), 32'd0);
        chk("single_keep_mul_a", 32'(bus.MUL_A), 32'd300);
        // Pointer now 2: probe without handshakes
        bus.REQ_VALID = 4'b1011;
        #1;
        chk("ptr2_probe_a", 32'(bus.REQ_READY), 32'b1000);
        bus.REQ_VALID = 4'b1111;
        #1;
        chk("ptr2_probe_b", 32'(bus.REQ_READY), 32'b0100);
        bus.REQ_VALID = 4'b0000;
        bus.RES_READY = 1'b0;
        tick();

        // Backpressure on 511*511 with other requests pending
        set_op(2, 511, 511);
        set_op(3, 7, 9);
        bus.REQ_VALID = 4'b1110;
        #1;
        chk("bp_grant", 32'(bus.REQ_READY), 32'b0100);
        tick();
        bus.REQ_VALID = 4'b1010;
        chk("bp_mul_rv", 32'(bus.RES_VALID), 32'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rv", 32'(bus.RES_VALID), 32'd1);
            chk("bp_data", 32'(bus.RES_DATA), 32'd261121);
            chk("bp_id", 32'(bus.RES_ID), 32'd2);
            chk("bp_req_ready", 32'(bus.REQ_READY), 32'd0);
            tick();
        end
        chk("bp_still_rv", 32'(bus.RES_VALID), 32'd1);
        bus.RES_READY = 1'b1;
        tick();
        chk("bp_release_rv", 32'(bus.RES_VALID), 32'd0);
        run_one(4'b1000, 3, 63, 1'b1);
        bus.REQ_VALID = 4'b0000;

        // Wrap and skip: move pointer to 3, then requesters 0 and 2 alternate
        set_op(2, 5, 6);
        bus.REQ_VALID = 4'b0100;
        #1;
        run_one(4'b0100, 2, 30, 1'b1);
        set_op(0, 11, 13);
        set_op(2, 17, 19);
        bus.REQ_VALID = 4'b0101;
        #1;
        run_one(4'b0001, 0, 143, 1'b0);
        run_one(4'b0100, 2, 323, 1'b0);
        run_one(4'b0001, 0, 143, 1'b0);
        run_one(4'b0100, 2, 323, 1'b0);
        bus.REQ_VALID = 4'b0000;

        // Reset while in MUL
        set_op(3, 100, 200);
        bus.REQ_VALID = 4'b1000;
        #1;
        chk("rm_grant", 32'(bus.REQ_READY), 32'b1000);
        tick();
        bus.REQ_VALID = 4'b0000;
        chk("rm_mul_a", 32'(bus.MUL_A), 32'd100);
        RST_N = 1'b0;
        tick();
        chk("rm_rv", 32'(bus.RES_VALID), 32'd0);
        chk("rm_data", 32'(bus.RES_DATA), 32'd0);
        chk("rm_id", 32'(bus.RES_ID), 32'd0);
        chk("rm_mul_a0", 32'(bus.MUL_A), 32'd0);
        chk("rm_mul_b0", 32'(bus.MUL_B), 32'd0);
        chk("rm_req_ready", 32'(bus.REQ_READY), 32'd0);
        RST_N = 1'b1;
        tick();
        chk("rm_post_rv", 32'(bus.RES_VALID), 32'd0);

        // Round robin from pointer 0, all requesters continuously valid
        for (int i = 0; i < NUM_REQ; i++) set_op(i, i + 2, 10);
        bus.REQ_VALID = 4'b1111;
        #1;
        run_one(4'b0001, 0, 20, 1'b0);
        run_one(4'b0010, 1, 30, 1'b0);
        run_one(4'b0100, 2, 40, 1'b0);
        run_one(4'b1000, 3, 50, 1'b0);
        run_one(4'b0001, 0, 20, 1'b0);
        bus.REQ_VALID = 4'b0000;
        tick();

        // Datapath sweep through requester 0
        for (int a = 0; a < 512; a++) begin
            set_op(0, a, 511);
            bus.REQ_VALID = 4'b0001;
            #1;
            run_one(4'b0001, 0, a * 511, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                set_op(0, vals[i], vals[j]);
                bus.REQ_VALID = 4'b0001;
                #1;
                run_one(4'b0001, 0, vals[i] * vals[j], 1'b1);
            end
        end
        tick();
        tick();

        // Every result pulse follows a grant; only the reset-discarded grant lacks one
        chk("rv_vs_grant", 32'(n_rv_rise), 32'(n_grant - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
